formula_arbiter: RTL and testbench

FORMULA_ARBITER -- requirements
Module: formula_arbiter

---
 rtl/formula_pkg.sv | 22 ++
 rtl/formula_arbiter_if.sv | 33 +++
 rtl/formula_pipe.sv | 54 +++++
 rtl/formula_arbiter.sv | 121 ++++++++++++
 tb/tb_formula_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/formula_pkg.sv
// Shared types and width helpers for the formula arbiter slice.
package formula_pkg;

    localparam int WIDTH_MAX = 32;
    localparam int ID_MAX = 3;
    localparam int QW = 2 * WIDTH_MAX + 7;

    function automatic int res_w(input int w);
        return 2 * w + 7;
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sized for the widest supported operand; instances use the low bits.
    typedef struct packed {
        logic signed [QW-1:0] q;
        logic [ID_MAX-1:0]    id;
    } fifo_entry_t;

endpackage

// File: rtl/formula_arbiter_if.sv
// Request/result handshake bundle between requesters and the arbiter.
interface formula_arbiter_if
    import formula_pkg::*;
#(
    parameter int width = 8,
    parameter int N = 4
) ();

    localparam int RW = res_w(width);
    localparam int IW = id_w(N);

    logic [N-1:0]         req_vld;
    logic [N-1:0]         req_rdy;
    logic [N*width-1:0]   req_a;
    logic [N*width-1:0]   req_b;
    logic [N*width-1:0]   req_c;
    logic [N*width-1:0]   req_d;
    logic                 res_vld;
    logic                 res_rdy;
    logic signed [RW-1:0] res_q;
    logic [IW-1:0]        res_id;

    modport master (
        output req_vld, req_a, req_b, req_c, req_d, res_rdy,
        input  req_rdy, res_vld, res_q, res_id
    );

    modport slave (
        input  req_vld, req_a, req_b, req_c, req_d, res_rdy,
        output req_rdy, res_vld, res_q, res_id
    );

endinterface

// File: rtl/formula_pipe.sv
// Two-stage pipeline computing (a-b)*(3c+1) - 4d with valid/id sideband.
module formula_pipe
    import formula_pkg::*;
#(
    parameter int width = 8,
    parameter int IW = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_vld,
    input  logic signed [width-1:0]        in_a,
    input  logic signed [width-1:0]        in_b,
    input  logic signed [width-1:0]        in_c,
    input  logic signed [width-1:0]        in_d,
    input  logic [IW-1:0]                  in_id,
    output logic                           out_vld,
    output logic signed [res_w(width)-1:0] out_p,
    output logic [IW-1:0]                  out_id
);

    localparam int RW = res_w(width);
    localparam int DW = width + 1;
    localparam int TW = width + 2;

    logic signed [DW-1:0] s1_diff;
    logic signed [TW-1:0] s1_tri;
    logic signed [TW-1:0] s1_quad;
    logic [IW-1:0]        s1_id;
    logic                 s1_vld;
    logic signed [TW-1:0] c_x;

    assign c_x = TW'(in_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            s1_vld  <= in_vld;
            out_vld <= s1_vld;
        end
    end

    // Datapath carries no reset; the valids gate everything downstream.
    always_ff @(posedge clk) begin
        s1_diff <= DW'(in_a) - DW'(in_b);
        s1_tri  <= c_x + c_x + c_x + TW'(1);
        s1_quad <= TW'(in_d) <<< 2;
        s1_id   <= in_id;
        out_p   <= RW'(s1_diff) * RW'(s1_tri) - RW'(s1_quad);
        out_id  <= s1_id;
    end

endmodule

// File: rtl/formula_arbiter.sv
// Round-robin arbiter with credit-limited formula pipeline and in-order result FIFO.
module formula_arbiter
    import formula_pkg::*;
#(
    parameter int width = 8,
    parameter int N = 4,
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    formula_arbiter_if.slave bus
);

    localparam int RW = res_w(width);
    localparam int IW = id_w(N);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0]        ptr;
    logic [IW-1:0]        gnt;
    logic                 found;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 pop;
    logic                 push;
    logic signed [RW-1:0] p;
    logic [IW-1:0]        p_id;
    fifo_entry_t          mem [DEPTH];
    fifo_entry_t          ent_w;
    fifo_entry_t          head;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        fcnt;
    logic                 unused_head;
    int                   j;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && bus.req_vld[j]) begin
                found = 1'b1;
                gnt   = IW'(j);
            end
        end
    end

    assign bus.req_rdy = (found && !rst && cnt < CW'(DEPTH))
                       ? N'(1) << gnt : '0;
    assign accept = |(bus.req_vld & bus.req_rdy);
    assign pop    = bus.res_vld & bus.res_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            if (accept)
                ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
            if (accept && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !accept)
                cnt <= cnt - 1'b1;
        end
    end

    formula_pipe #(
        .width (width),
        .IW    (IW)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (accept),
        .in_a    (bus.req_a[gnt*width +: width]),
        .in_b    (bus.req_b[gnt*width +: width]),
        .in_c    (bus.req_c[gnt*width +: width]),
        .in_d    (bus.req_d[gnt*width +: width]),
        .in_id   (gnt),
        .out_vld (push),
        .out_p   (p),
        .out_id  (p_id)
    );

    always_comb begin
        ent_w    = '0;
        ent_w.q  = QW'(p >>> 1);
        ent_w.id = ID_MAX'(p_id);
    end

    // Credits cap outstanding work at DEPTH, so push never sees a full FIFO.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ent_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                fcnt <= fcnt + 1'b1;
            else if (pop && !push)
                fcnt <= fcnt - 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign unused_head = ^head;
    assign bus.res_vld = (fcnt != '0);
    assign bus.res_q   = bus.res_vld ? head.q[RW-1:0] : '0;
    assign bus.res_id  = bus.res_vld ? head.id[IW-1:0] : '0;

endmodule

// File: tb/tb_formula_arbiter.sv
// Scoreboard bench for formula_arbiter (width=8, N=4, DEPTH=4).
module tb_formula_arbiter;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int D  = 4;
    localparam int RW = 2 * W + 7;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    formula_arbiter_if #(.width(W), .N(NR)) bus ();

    formula_arbiter #(.width(W), .N(NR), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [RW-1:0] exp_q [$];
    logic [1:0]           exp_id [$];

    int checks = 0;
    int failures = 0;
    int mptr = 0;
    int mcnt = 0;
    int last_gnt = -1;
    int n_acc = 0;
    int n_pop = 0;
    bit popped = 0;
    bit hold_vld = 0;
    logic signed [RW-1:0] hold_q;
    logic [1:0]           hold_id;
    logic signed [RW-1:0] last_q;
    logic [1:0]           last_id;

    function automatic longint model(longint a, longint b, longint c, longint d);
        longint v;
        v = (a - b) * (3 * c + 1) - 4 * d;
        return v >>> 1;
    endfunction

    task automatic set_ops(int i, int a, int b, int c, int d);
        bus.req_a[i*W +: W] = W'(a);
        bus.req_b[i*W +: W] = W'(b);
        bus.req_c[i*W +: W] = W'(c);
        bus.req_d[i*W +: W] = W'(d);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++)
            set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    // One clock: check handshake against the model, score pops, record accepts.
    task automatic step();
        logic [NR-1:0] er;
        logic signed [RW-1:0] eq;
        logic [1:0] ei;
        longint va, vb, vc, vd;
        int g;
        #1;
        er = '0;
        g = -1;
        if (!rst && mcnt < D)
            for (int k = 0; k < NR; k++)
                if (g < 0 && bus.req_vld[(mptr + k) % NR]) g = (mptr + k) % NR;
        if (g >= 0) er[g] = 1'b1;
        checks++;
        if (bus.req_rdy !== er) begin
            failures++;
            $display("FAIL req_rdy got=%b exp=%b", bus.req_rdy, er);
        end
        if (hold_vld && bus.res_vld) begin
            checks++;
            if (bus.res_q !== hold_q || bus.res_id !== hold_id) begin
                failures++;
                $display("FAIL res_stable got=%0d/%0d exp=%0d/%0d",
                         bus.res_q, bus.res_id, hold_q, hold_id);
            end
        end
        hold_vld = bus.res_vld && !bus.res_rdy;
        hold_q   = bus.res_q;
        hold_id  = bus.res_id;
        popped   = 0;
        last_gnt = -1;
        if (bus.res_vld && bus.res_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL res_unexpected got=%0d id=%0d exp=none",
                         bus.res_q, bus.res_id);
            end else begin
                eq = exp_q.pop_front();
                ei = exp_id.pop_front();
                if (bus.res_q !== eq || bus.res_id !== ei) begin
                    failures++;
                    $display("FAIL res_data got=%0d id=%0d exp=%0d id=%0d",
                             bus.res_q, bus.res_id, eq, ei);
                end
            end
            popped  = 1;
            last_q  = bus.res_q;
            last_id = bus.res_id;
            n_pop++;
            mcnt--;
        end
        for (int i = 0; i < NR; i++) begin
            if (bus.req_vld[i] && bus.req_rdy[i]) begin
                va = $signed(bus.req_a[i*W +: W]);
                vb = $signed(bus.req_b[i*W +: W]);
                vc = $signed(bus.req_c[i*W +: W]);
                vd = $signed(bus.req_d[i*W +: W]);
                exp_q.push_back(RW'(model(va, vb, vc, vd)));
                exp_id.push_back(2'(i));
                last_gnt = i;
                mptr = (i + 1) % NR;
                mcnt++;
                n_acc++;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.res_vld !== 1'b0 || bus.req_rdy !== '0 ||
            bus.res_q !== '0 || bus.res_id !== '0) begin
            failures++;
            $display("FAIL reset_outputs got vld=%b rdy=%b q=%0d id=%0d exp=0",
                     bus.res_vld, bus.req_rdy, bus.res_q, bus.res_id);
        end
        exp_q.delete();
        exp_id.delete();
        mptr = 0;
        mcnt = 0;
        hold_vld = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.req_vld = '0;
        bus.res_rdy = 1'b1;
        n = 0;
        while ((mcnt != 0 || exp_q.size() != 0) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (mcnt != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.req_vld = '1;
        bus.res_rdy = 1'b1;
        rand_ops();
        @(negedge clk);
        apply_reset();
    endtask

    task automatic test_basic();
        bus.req_vld = 4'b0001;
        bus.res_rdy = 1'b1;
        set_ops(0, 10, 3, 2, 1);
        step();
        bus.req_vld = '0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++;
            if (bus.res_vld !== (c == 3)) begin
                failures++;
                $display("FAIL basic_latency cycle=%0d got=%b exp=%b",
                         c, bus.res_vld, c == 3);
            end
            if (c == 3) begin
                checks++;
                if (bus.res_q !== 23'sd22 || bus.res_id !== 2'd0) begin
                    failures++;
                    $display("FAIL basic_value got=%0d id=%0d exp=22 id=0",
                             bus.res_q, bus.res_id);
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_extremes();
        logic signed [RW-1:0] got [2];
        int n, k;
        bus.res_rdy = 1'b1;
        bus.req_vld = 4'b0001;
        set_ops(0, -128, 127, -128, -128);
        step();
        set_ops(0, 0, 1, 0, 0);
        step();
        bus.req_vld = '0;
        n = 0;
        k = 0;
        while (k < 2 && n < 20) begin
            step();
            if (popped) begin
                got[k] = last_q;
                k++;
            end
            n++;
        end
        checks++;
        if (k != 2 || got[0] !== 23'sd49088 || got[1] !== -23'sd1) begin
            failures++;
            $display("FAIL extremes got=%0d,%0d n=%0d exp=49088,-1",
                     got[0], got[1], k);
        end
        drain();
    endtask

    task automatic test_fairness();
        int g [6];
        int ids [$];
        apply_reset();
        bus.req_vld = '1;
        bus.res_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            step();
            g[k] = last_gnt;
            if (popped) ids.push_back(int'(last_id));
        end
        bus.req_vld = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (popped) ids.push_back(int'(last_id));
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (g[k] != k % NR || ids.size() != 6 || ids[k] != k % NR) begin
                failures++;
                $display("FAIL fairness k=%0d got grant=%0d exp=%0d",
                         k, g[k], k % NR);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int a0, p0, n;
        int ids [$];
        apply_reset();
        bus.req_vld = '1;
        bus.res_rdy = 1'b0;
        a0 = n_acc;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            step();
        end
        #1;
        checks++;
        if (n_acc - a0 != D || bus.req_rdy !== '0) begin
            failures++;
            $display("FAIL bp_accepts got=%0d rdy=%b exp=%0d rdy=0",
                     n_acc - a0, bus.req_rdy, D);
        end
        bus.res_rdy = 1'b1;
        p0 = n_pop;
        a0 = n_acc;
        n = 0;
        while (n_pop - p0 < D && n < 20) begin
            step();
            if (popped) ids.push_back(int'(last_id));
            n++;
        end
        checks++;
        if (ids.size() != D || ids[0] != 0 || ids[1] != 1 ||
            ids[2] != 2 || ids[3] != 3) begin
            failures++;
            $display("FAIL bp_order got n=%0d exp=0,1,2,3", ids.size());
        end
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (n_acc == a0) begin
            failures++;
            $display("FAIL bp_resume got=0 accepts exp>0");
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int a0, p0;
        apply_reset();
        bus.req_vld = '1;
        bus.res_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            step();
        end
        bus.req_vld = '0;
        for (int k = 0; k < 3; k++) step();
        #1;
        checks++;
        if (bus.res_vld !== 1'b1) begin
            failures++;
            $display("FAIL mid_pending got=%b exp=1", bus.res_vld);
        end
        @(negedge clk);
        apply_reset();
        bus.req_vld = '1;
        #1;
        checks++;
        if (bus.req_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL mid_grant got=%b exp=0001", bus.req_rdy);
        end
        a0 = n_acc;
        p0 = n_pop;
        step();
        checks++;
        if (n_acc != a0 + 1) begin
            failures++;
            $display("FAIL mid_first_accept got=%0d exp=1", n_acc - a0);
        end
        bus.req_vld = '0;
        bus.res_rdy = 1'b1;
        for (int k = 0; k < 8; k++) step();
        checks++;
        if (n_pop != p0 + 1) begin
            failures++;
            $display("FAIL mid_stale got=%0d pops exp=1", n_pop - p0);
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 120; k++) begin
            bus.req_vld = NR'($urandom);
            bus.res_rdy = ($urandom_range(0, 3) != 0);
            rand_ops();
            step();
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        bus.req_vld = '0;
        bus.res_rdy = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_c = '0;
        bus.req_d = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
